// File: rtl/shape_renderer.sv
// shape_renderer: plots a SHAPE_W x SHAPE_H solid block into a 160x120 VGA adapter
// whenever the toggle-coded pulse input changes level. One pixel is written per clock,
// raster order with the column index running fastest. Pixels that fall off-screen are
// suppressed, but the counters still step through them, so every phase has a fixed length.
// Optional feature: define RENDER_ERASE_EN to first repaint the previous shape position in
// BG_COLOUR before each redraw. With it undefined, old shapes are left on screen as trails.
module shape_renderer #(
    parameter int unsigned SHAPE_W   = 4,
    parameter int unsigned SHAPE_H   = 4,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pulse,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    localparam logic [4:0] ColLast = 5'(SHAPE_W - 1);
    localparam logic [4:0] RowLast = 5'(SHAPE_H - 1);

    typedef enum logic [2:0] {StIdle, StErase, StLatch, StDraw, StDone} state_e;

    state_e     state_q, state_d;
    logic [1:0] sync_q, sync_d;
    logic       sync_dly_q, sync_dly_d;
    logic       req_q, req_d;
    logic       pending_q, pending_d;
    logic       old_valid_q, old_valid_d;
    logic [7:0] old_x_q, old_x_d;
    logic [6:0] old_y_q, old_y_d;
    logic [2:0] cur_colour_q, cur_colour_d;
    logic [4:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;

    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic       pix_visible;
    logic       last_pixel;
    state_e     start_state;

    // Both ERASE and DRAW walk the block at old_x/old_y; LATCH has already moved it for DRAW.
    assign pix_x       = {1'b0, old_x_q} + {4'b0, col_q};
    assign pix_y       = {1'b0, old_y_q} + {3'b0, row_q};
    assign pix_visible = (pix_x <= 9'd159) && (pix_y <= 8'd119);
    assign last_pixel  = (col_q == ColLast) && (row_q == RowLast);

`ifdef RENDER_ERASE_EN
    // Nothing to erase until a shape has been drawn since reset.
    assign start_state = old_valid_q ? StErase : StLatch;
`else
    assign start_state = StLatch;
    logic unused_old_valid;
    assign unused_old_valid = old_valid_q;
`endif

    // Next-state: request detection, pending tracking, FSM and pixel generation.
    always_comb begin
        sync_d       = {sync_q[0], pulse};
        sync_dly_d   = sync_q[1];
        req_d        = sync_q[1] ^ sync_dly_q;
        state_d      = state_q;
        pending_d    = pending_q;
        old_valid_d  = old_valid_q;
        old_x_d      = old_x_q;
        old_y_d      = old_y_q;
        cur_colour_d = cur_colour_q;
        col_d        = col_q;
        row_d        = row_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;

        // One-deep request buffer while busy; extra requests are dropped.
        if (state_q != StIdle && req_q && !pending_q) begin
            pending_d = 1'b1;
        end

        if (state_q == StErase || state_q == StDraw) begin
            if (pix_visible) begin
                plot_d   = 1'b1;
                x_d      = pix_x[7:0];
                y_d      = pix_y[6:0];
                colour_d = (state_q == StErase) ? BG_COLOUR : cur_colour_q;
            end
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? 5'd0 : row_q + 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (req_q) begin
                    state_d = start_state;
                end
            end
            StErase: begin
                if (last_pixel) begin
                    state_d = StLatch;
                end
            end
            StLatch: begin
                old_x_d      = x_in;
                old_y_d      = y_in;
                cur_colour_d = colour_in;
                old_valid_d  = 1'b1;
                state_d      = StDraw;
            end
            StDraw: begin
                if (last_pixel) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // A request landing in this very cycle counts as pending.
                state_d   = (pending_q || req_q) ? start_state : StIdle;
                pending_d = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            sync_q       <= '0;
            sync_dly_q   <= 1'b0;
            req_q        <= 1'b0;
            pending_q    <= 1'b0;
            old_valid_q  <= 1'b0;
            old_x_q      <= '0;
            old_y_q      <= '0;
            cur_colour_q <= '0;
            col_q        <= '0;
            row_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            sync_dly_q   <= sync_dly_d;
            req_q        <= req_d;
            pending_q    <= pending_d;
            old_valid_q  <= old_valid_d;
            old_x_q      <= old_x_d;
            old_y_q      <= old_y_d;
            cur_colour_q <= cur_colour_d;
            col_q        <= col_d;
            row_q        <= row_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_shape_renderer.sv
// Bench for shape_renderer: expected pixels are queued when a request is issued and popped
// as plot strobes appear. Busy-period lengths, request latency and reset behaviour are
// checked directly. Expectations follow RENDER_ERASE_EN the same way the design does.
module tb_shape_renderer;

    localparam int W = 4;
    localparam int H = 4;
    localparam logic [2:0] BG = 3'b000;
    localparam int FIRST = W * H + 2;
`ifdef RENDER_ERASE_EN
    localparam int PH = 2 * W * H + 2;
`else
    localparam int PH = W * H + 2;
`endif

    logic       clk;
    logic       resetn;
    logic       pulse;
    logic [7:0] x_in;
    logic [6:0] y_in;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    shape_renderer #(
        .SHAPE_W  (W),
        .SHAPE_H  (H),
        .BG_COLOUR(BG)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .pulse    (pulse),
        .x_in     (x_in),
        .y_in     (y_in),
        .colour_in(colour_in),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];
    logic [17:0] exp_pix;

    // Model of where the shape currently sits on screen.
    logic       m_valid = 1'b0;
    logic [7:0] m_x = '0;
    logic [6:0] m_y = '0;
    logic [7:0] m_lx = '0;
    logic [6:0] m_ly = '0;
    logic [2:0] m_lc = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic push_rect(input int x0, input int y0, input logic [2:0] c);
        logic [7:0] px;
        logic [6:0] py;
        for (int r = 0; r < H; r++) begin
            for (int k = 0; k < W; k++) begin
                if (x0 + k <= 159 && y0 + r <= 119) begin
                    px = 8'(x0 + k);
                    py = 7'(y0 + r);
                    exp_q.push_back({px, py, c});
                    m_lx = px;
                    m_ly = py;
                    m_lc = c;
                end
            end
        end
    endtask

    // Expected pixels for one accepted request.
    task automatic push_move(input logic [7:0] nx, input logic [6:0] ny, input logic [2:0] nc);
`ifdef RENDER_ERASE_EN
        if (m_valid) push_rect(int'(m_x), int'(m_y), BG);
`endif
        push_rect(int'(nx), int'(ny), nc);
        m_valid = 1'b1;
        m_x     = nx;
        m_y     = ny;
    endtask

    task automatic wait_busy(output int lat);
        lat = 0;
        while (!busy && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Count busy cycles; optionally toggle pulse on busy cycles ta / tb (0 = never).
    task automatic count_busy(input int ta, input int tb, output int n);
        n = 0;
        while (busy && n < 300) begin
            n++;
            if (n == ta || n == tb) pulse = ~pulse;
            @(negedge clk);
        end
    endtask

    task automatic do_move(input logic [7:0] nx, input logic [6:0] ny, input logic [2:0] nc,
                           input int n_acc, input int ta, input int tb, input int exp_len,
                           input string tag);
        int lat;
        int n;
        x_in      = nx;
        y_in      = ny;
        colour_in = nc;
        for (int i = 0; i < n_acc; i++) push_move(nx, ny, nc);
        pulse = ~pulse;
        wait_busy(lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        count_busy(ta, tb, n);
        check({tag, "_busy_len"}, 32'(n), 32'(exp_len));
        check({tag, "_all_plotted"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_hold"}, 32'({x, y, colour}), 32'({m_lx, m_ly, m_lc}));
    endtask

    // Scoreboard: every plot strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (plot) begin
            if (exp_q.size() == 0) begin
                check("plot_unexpected", 32'({x, y, colour}), 32'h3ffff);
            end else begin
                exp_pix = exp_q.pop_front();
                check("pixel", 32'({x, y, colour}), 32'(exp_pix));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int rst_cyc;

        resetn    = 1'b0;
        pulse     = 1'b0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;
        repeat (3) @(negedge clk);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // First request never erases.
        do_move(8'd10, 7'd0, 3'b100, 1, 0, 0, FIRST, "first");
        do_move(8'd10, 7'd1, 3'b100, 1, 0, 0, PH, "second");
        // Bottom-right corner: only four pixels on screen, phase length unchanged.
        do_move(8'd158, 7'd118, 3'b010, 1, 0, 0, PH, "corner");

        // Three requests in one busy period: one queued, third dropped.
        do_move(8'd20, 7'd30, 3'b101, 2, 2, 6, 2 * PH, "pending");
        repeat (30) @(negedge clk);
        check("pending_dropped_busy", 32'(busy), 32'd0);
        check("pending_dropped_q", 32'(exp_q.size()), 32'd0);

        // Request arriving exactly in the DONE cycle must not be lost.
        do_move(8'd40, 7'd50, 3'b110, 2, PH - 3, 0, 2 * PH, "done_req");

        // Reset while the 5th DRAW pixel is being generated.
        rst_cyc = 6;
`ifdef RENDER_ERASE_EN
        if (m_valid) rst_cyc += W * H;
`endif
        x_in      = 8'd60;
        y_in      = 7'd70;
        colour_in = 3'b001;
        push_move(8'd60, 7'd70, 3'b001);
        pulse = ~pulse;
        wait_busy(lat);
        check("rst_mid_latency", 32'(lat), 32'd4);
        repeat (rst_cyc - 1) @(negedge clk);
        #2;
        resetn = 1'b0;
        pulse  = 1'b0;
        #1;
        check("rst_mid_plot", 32'(plot), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_xyc", 32'({x, y, colour}), 32'd0);
        check("rst_mid_remaining", 32'(exp_q.size()), 32'd12);
        exp_q.delete();
        m_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_idle", 32'(busy), 32'd0);

        // After reset the next request draws without erasing.
        do_move(8'd80, 7'd90, 3'b111, 1, 0, 0, FIRST, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shape_renderer.md
SHAPE_RENDERER -- requirements
Module: shape_renderer

Interface
REQ-001 Parameter SHAPE_W, default 4: shape width in pixels, 1..16.
REQ-002 Parameter SHAPE_H, default 4: shape height in pixels, 1..16.
REQ-003 Parameter BG_COLOUR, default 3'b000: colour used to erase.
REQ-004 clk  input  1: single clock; all state changes on rising edge.
REQ-005 resetn  input  1: reset, asynchronous, active-low.
REQ-006 pulse  input  1: move request, toggle-coded; each level change is one request; asynchronous to clk.
REQ-007 x_in  input  8: new top-left X, sampled at request acceptance.
REQ-008 y_in  input  7: new top-left Y, sampled at request acceptance.
REQ-009 colour_in  input  3: shape colour, sampled with x_in/y_in.
REQ-010 x  output  8: pixel X to VGA adapter, registered.
REQ-011 y  output  7: pixel Y to VGA adapter, registered.
REQ-012 colour  output  3: pixel colour, registered.
REQ-013 plot  output  1: pixel write strobe, one clk per pixel, registered.
REQ-014 busy  output  1: high whenever FSM is not IDLE.

Function
REQ-015 pulse SHALL pass a 2-flop synchronizer; request = XOR of sync output and its 1-cycle delayed copy.
REQ-016 FSM states: IDLE, ERASE, LATCH, DRAW, DONE.
REQ-017 IDLE -> ERASE on request if old_valid=1, else IDLE -> LATCH.
REQ-018 Pulse change sampled at edge N SHALL produce request at edge N+2; FSM leaves IDLE at edge N+3.
REQ-019 ERASE: SHALL emit SHAPE_W*SHAPE_H pixels at stored old_x/old_y, colour=BG_COLOUR, raster order, column fastest, one per clk.
REQ-020 LATCH: one cycle, plot=0; capture x_in, y_in, colour_in into old_x, old_y, cur_colour; set old_valid=1.
REQ-021 DRAW: same pixel sequence as ERASE at the latched coordinates, colour=cur_colour.
REQ-022 DONE: one cycle, plot=0; -> LATCH if pending=1 and erase compiled out, -> ERASE if pending=1 and erase compiled in, else -> IDLE.
REQ-023 Pixel coordinate = base + column/row, computed 9-bit (X) / 8-bit (Y); pixel with X>159 or Y>119 SHALL have plot=0, counters still advance (fixed phase length).
REQ-024 Request while busy SHALL set pending (1-deep); further requests while pending=1 SHALL be dropped; pending cleared on leaving DONE.
REQ-025 Request in the same cycle as DONE SHALL be treated as pending (not lost).
REQ-026 x, y, colour hold last values when plot=0.
REQ-027 Phase length: erase+draw = 2*SHAPE_W*SHAPE_H+2 cycles.

Reset
REQ-028 resetn low SHALL asynchronously force state IDLE; x=0, y=0, colour=0, plot=0, busy=0, pending=0, old_valid=0, old_x=0, old_y=0, counters=0, synchronizer flops=0.
REQ-029 Reset mid-ERASE/DRAW SHALL abort the phase with no further plot; first request after release SHALL skip ERASE.
REQ-030 Deassertion takes effect on first rising clk edge after resetn goes high.

Configuration
REQ-031 Macro RENDER_ERASE_EN: defined -> ERASE state present per REQ-017/REQ-019.
REQ-032 RENDER_ERASE_EN undefined -> ERASE never entered; request goes IDLE -> LATCH; shapes leave trails; phase = SHAPE_W*SHAPE_H+2 cycles.

Verification
REQ-033 Reset, toggle pulse once with x_in=10, y_in=0, colour_in=3'b100 -> no ERASE; 16 plots at (10..13, 0..3) colour 100; busy low after DONE.
REQ-034 Second toggle with x_in=10, y_in=1 -> 16 plots at (10..13, 0..3) colour 000, then 16 at (10..13, 1..4) colour 100; total busy = 34 cycles.
REQ-035 x_in=158, y_in=118 -> only (158..159, 118..119) plotted (4 strobes), phase length still 16 cycles per phase.
REQ-036 Three toggles within one busy period -> exactly one extra erase/draw sequence, third request dropped.
REQ-037 resetn low during 5th DRAW pixel -> plot=0 immediately, all outputs 0; next request draws without erase.
REQ-038 RENDER_ERASE_EN undefined, two toggles -> no BG_COLOUR plots; each phase 18 cycles.
